// File: rtl/iso14443a_deframer.sv
// ISO 14443-A PICC deframer: strips SOC, assembles LSB-first bytes with odd parity, classifies short/standard frames.
// Optional CRC_A residue check enabled by defining CRC_A_CHECK_EN (adds out_crc_ok).
module iso14443a_deframer #(
  parameter int unsigned MAX_BYTES = 64,
  parameter int unsigned TIMEOUT   = 512,
  parameter int unsigned TW        = 10
) (
  input  logic       clk,
  input  logic       in_PoR,
  input  logic       in_bit,
  input  logic       in_bit_valid,
  input  logic       in_frame_end,
  output logic [7:0] out_byte,
  output logic       out_byte_valid,
  output logic       out_parity_err,
  output logic       out_short,
  output logic [6:0] out_short_data,
  output logic       out_frame_done,
  output logic       out_frame_err,
  output logic [6:0] out_byte_count,
  output logic       out_busy
`ifdef CRC_A_CHECK_EN
  ,
  output logic       out_crc_ok
`endif
);

  typedef enum logic {IDLE, DATA} state_t;

  state_t        state, state_next;
  logic [3:0]    bit_cnt, bit_cnt_next;
  logic [8:0]    shreg, shreg_next;
  logic [TW-1:0] tmo_cnt;
  logic [6:0]    byte_count_next;
  logic          soc, byte_done, overflow, timeout, finish;
  logic          frame_err_next, short_next;

  // The end-of-frame classification uses the post-bit counters so a bit
  // arriving together with in_frame_end is accounted for first.
  always_comb begin
    state_next      = state;
    soc             = 1'b0;
    byte_done       = 1'b0;
    overflow        = 1'b0;
    timeout         = 1'b0;
    finish          = 1'b0;
    frame_err_next  = 1'b0;
    short_next      = 1'b0;
    shreg_next      = shreg;
    bit_cnt_next    = bit_cnt;
    byte_count_next = out_byte_count;
    case (state)
      IDLE: begin
        if (in_bit_valid && !in_bit) begin
          soc        = 1'b1;
          state_next = DATA;
        end
      end
      DATA: begin
        if (in_bit_valid) begin
          shreg_next   = {in_bit, shreg[8:1]};
          byte_done    = (bit_cnt == 4'd8);
          bit_cnt_next = byte_done ? '0 : bit_cnt + 4'd1;
        end
        overflow = byte_done && (out_byte_count == 7'(MAX_BYTES));
        if (byte_done && !overflow) byte_count_next = out_byte_count + 7'd1;
        timeout = !in_bit_valid && (tmo_cnt == TW'(TIMEOUT - 1));
        if (overflow) begin
          frame_err_next = 1'b1;
        end else if (in_frame_end) begin
          short_next     = (bit_cnt_next == 4'd7) && (byte_count_next == '0);
          frame_err_next = !short_next &&
                           !((bit_cnt_next == '0) && (byte_count_next != '0));
        end else begin
          frame_err_next = 1'b1;
        end
        finish = overflow || in_frame_end || timeout;
        if (finish) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef CRC_A_CHECK_EN
  logic [15:0] crc, crc_next;

  // Reflected CRC_A over data bits only; the parity slot (bit_cnt 8) is skipped.
  always_comb begin
    crc_next = crc;
    if (state == DATA && in_bit_valid && bit_cnt != 4'd8)
      crc_next = {1'b0, crc[15:1]} ^ ((crc[0] ^ in_bit) ? 16'h8408 : 16'h0000);
  end
`endif

  always_ff @(posedge clk) begin
    if (!in_PoR) state <= IDLE;
    else         state <= state_next;
  end

  assign out_busy = (state == DATA);

  always_ff @(posedge clk) begin
    if (!in_PoR) begin
      bit_cnt        <= '0;
      shreg          <= '0;
      tmo_cnt        <= '0;
      out_byte       <= '0;
      out_byte_valid <= 1'b0;
      out_parity_err <= 1'b0;
      out_short      <= 1'b0;
      out_short_data <= '0;
      out_frame_done <= 1'b0;
      out_frame_err  <= 1'b0;
      out_byte_count <= '0;
`ifdef CRC_A_CHECK_EN
      crc            <= 16'h6363;
      out_crc_ok     <= 1'b0;
`endif
    end else begin
      out_byte_valid <= 1'b0;
      out_frame_done <= 1'b0;
      if (soc) begin
        bit_cnt        <= '0;
        shreg          <= '0;
        tmo_cnt        <= '0;
        out_byte_count <= '0;
        out_short      <= 1'b0;
        out_short_data <= '0;
        out_frame_err  <= 1'b0;
`ifdef CRC_A_CHECK_EN
        crc            <= 16'h6363;
        out_crc_ok     <= 1'b0;
`endif
      end else if (state == DATA) begin
        shreg          <= shreg_next;
        bit_cnt        <= bit_cnt_next;
        out_byte_count <= byte_count_next;
        tmo_cnt        <= in_bit_valid ? '0 : tmo_cnt + TW'(1);
`ifdef CRC_A_CHECK_EN
        crc            <= crc_next;
`endif
        if (byte_done && !overflow) begin
          out_byte       <= shreg_next[7:0];
          out_parity_err <= ~^shreg_next;
          out_byte_valid <= 1'b1;
        end
        if (finish) begin
          bit_cnt        <= '0;
          tmo_cnt        <= '0;
          out_frame_done <= 1'b1;
          out_frame_err  <= frame_err_next;
          out_short      <= short_next;
          if (short_next) out_short_data <= shreg_next[8:2];
`ifdef CRC_A_CHECK_EN
          out_crc_ok     <= !short_next && !frame_err_next &&
                            (crc_next == 16'h0000) && (byte_count_next >= 7'd3);
`endif
        end
      end
    end
  end

endmodule
